// File: rtl/multi_blink_pkg.sv
// Shared types for the multi-channel blinker: channel modes and the configuration
// word handed from the write port to each channel.
package multi_blink_pkg;

   // Config fields are carried at this width and narrowed inside each channel,
   // so WIDTH and COUNT_WIDTH must not exceed it.
   localparam int CFG_MAX_W = 32;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_PULSE = 2'd3
   } mode_t;

   typedef struct packed {
      mode_t                mode;
      logic [CFG_MAX_W-1:0] period;
      logic [CFG_MAX_W-1:0] high;
      logic [CFG_MAX_W-1:0] count;
   } cfg_t;

   function automatic logic is_running(input mode_t m);
      return (m == MODE_BLINK) || (m == MODE_PULSE);
   endfunction

endpackage

// File: rtl/multi_blink_channel.sv
// One indicator channel: holds its mode and timing, advances phase on the shared
// tick and counts down whole periods in PULSE mode.
module blink_channel
   import multi_blink_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int COUNT_WIDTH = 8
) (
   input  logic clock,
   input  logic reset_n,
   input  logic tick,
   input  logic load,
   input  cfg_t cfg,
   output logic blink_out,
   output logic busy
);

   mode_t                  mode;
   logic [WIDTH-1:0]       period;
   logic [WIDTH-1:0]       high;
   logic [WIDTH-1:0]       phase;
   logic [COUNT_WIDTH-1:0] remaining;
   logic [WIDTH-1:0]       last_phase;
   logic                   wrap;
   logic                   zero_count;

   // A period of 0 behaves as 1, so the last phase index is 0 in both cases.
   assign last_phase = (period == '0) ? '0 : period - WIDTH'(1);
   assign wrap       = (phase == last_phase);
   assign zero_count = (cfg.count[COUNT_WIDTH-1:0] == '0);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         mode      <= MODE_OFF;
         period    <= '0;
         high      <= '0;
         phase     <= '0;
         remaining <= '0;
      end else if (load) begin
         mode      <= (cfg.mode == MODE_PULSE && zero_count) ? MODE_OFF : cfg.mode;
         period    <= cfg.period[WIDTH-1:0];
         high      <= cfg.high[WIDTH-1:0];
         remaining <= cfg.count[COUNT_WIDTH-1:0];
         phase     <= '0;
      end else if (tick && is_running(mode)) begin
         if (wrap) begin
            phase <= '0;
            if (mode == MODE_PULSE) begin
               remaining <= remaining - COUNT_WIDTH'(1);
               if (remaining == COUNT_WIDTH'(1))
                  mode <= MODE_OFF;
            end
         end else begin
            phase <= phase + WIDTH'(1);
         end
      end
   end

   always_comb begin
      blink_out = 1'b0;
      case (mode)
         MODE_OFF:   blink_out = 1'b0;
         MODE_ON:    blink_out = 1'b1;
         MODE_BLINK: blink_out = (phase < high);
         MODE_PULSE: blink_out = (phase < high);
         default:    blink_out = 1'b0;
      endcase
   end

   assign busy = is_running(mode);

   // Upper config bits beyond this channel's widths are zero-filled by the top.
   if (WIDTH < CFG_MAX_W) begin : g_unused_w
      logic unused_w;
      assign unused_w = ^{cfg.period[CFG_MAX_W-1:WIDTH], cfg.high[CFG_MAX_W-1:WIDTH]};
   end
   if (COUNT_WIDTH < CFG_MAX_W) begin : g_unused_c
      logic unused_c;
      assign unused_c = ^cfg.count[CFG_MAX_W-1:COUNT_WIDTH];
   end

endmodule

// File: rtl/multi_blink.sv
// NUM_CHANNELS indicator outputs driven from one shared prescaler tick, configured
// one channel at a time through a valid/ready write port.
module multi_blink
   import multi_blink_pkg::*;
#(
   parameter  int NUM_CHANNELS = 4,
   parameter  int WIDTH        = 16,
   parameter  int PRESCALE     = 100000,
   parameter  int COUNT_WIDTH  = 8,
   localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [CH_W-1:0]         cfg_channel,
   input  logic [1:0]              cfg_mode,
   input  logic [WIDTH-1:0]        cfg_period,
   input  logic [WIDTH-1:0]        cfg_high,
   input  logic [COUNT_WIDTH-1:0]  cfg_count,
   output logic [NUM_CHANNELS-1:0] blink_out,
   output logic [NUM_CHANNELS-1:0] busy
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0]         prescaler;
   logic                    tick;
   logic                    accept;
   logic [NUM_CHANNELS-1:0] load;
   cfg_t                    cfg;

   assign tick   = (prescaler == PS_W'(PRESCALE - 1));
   assign accept = cfg_valid && cfg_ready;

   // Ready drops for exactly the cycle after an accept, capping writes at one per two cycles.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         prescaler <= '0;
         cfg_ready <= 1'b0;
      end else begin
         prescaler <= tick ? '0 : prescaler + PS_W'(1);
         cfg_ready <= !accept;
      end
   end

   assign cfg.mode   = mode_t'(cfg_mode);
   assign cfg.period = CFG_MAX_W'(cfg_period);
   assign cfg.high   = CFG_MAX_W'(cfg_high);
   assign cfg.count  = CFG_MAX_W'(cfg_count);

   // Indices with no matching channel decode to no load and are silently dropped.
   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      assign load[i] = accept && (cfg_channel == CH_W'(i));

      blink_channel #(
         .WIDTH       (WIDTH),
         .COUNT_WIDTH (COUNT_WIDTH)
      ) u_ch (
         .clock     (clock),
         .reset_n   (reset_n),
         .tick      (tick),
         .load      (load[i]),
         .cfg       (cfg),
         .blink_out (blink_out[i]),
         .busy      (busy[i])
      );
   end

endmodule
